// File: rtl/processing_unit_p_pkg.sv
// rtl/processing_unit_p_pkg.sv - shared select codes, opcodes and flag positions for processing_unit_p
package processing_unit_p_pkg;

    typedef enum logic [1:0] {
        BUS2_ALU  = 2'd0,
        BUS2_BUS1 = 2'd1,
        BUS2_MEM  = 2'd2,
        BUS2_ZERO = 2'd3
    } bus2_sel_e;

    // bus_1 special sources sit just above the general registers
    localparam int SEL1_PC_OFS = 0;
    localparam int SEL1_SP_OFS = 1;
    localparam int SEL1_Y_OFS  = 2;

    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_AND = 3;
    localparam int OP_NOT = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/processing_unit_p_alu_flags.sv
// rtl/processing_unit_p_alu_flags.sv - combinational ALU producing result and {Z,N,C,V}
import processing_unit_p_pkg::*;

module alu_flags_p #(
    parameter int WORD_SIZE = 16,
    parameter int OP_SIZE   = 5
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [OP_SIZE-1:0]   opcode,
    output logic [WORD_SIZE-1:0] result,
    output logic [3:0]           flags
);

    localparam int MSB = WORD_SIZE - 1;

    logic [WORD_SIZE:0] wide;
    logic               carry;
    logic               ovf;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OP_SIZE'(OP_ADD): begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[MSB:0];
                carry  = wide[WORD_SIZE];
                ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SIZE'(OP_SUB): begin
                // top bit of the widened difference is the borrow
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[MSB:0];
                carry  = wide[WORD_SIZE];
                ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SIZE'(OP_AND): result = a & b;
            OP_SIZE'(OP_NOT): result = ~b;
            default: result = '0;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[MSB];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/processing_unit_p.sv
// rtl/processing_unit_p.sv - two-bus datapath with register file, PC, stack pointer and memory stall
import processing_unit_p_pkg::*;

module processing_unit_p #(
    parameter int                   WORD_SIZE   = 16,
    parameter int                   NUM_REGS    = 8,
    parameter int                   OP_SIZE     = 5,
    parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
    parameter logic [WORD_SIZE-1:0] STACK_TOP   = WORD_SIZE'(16'hFFFF),
    parameter logic [WORD_SIZE-1:0] STACK_LIMIT = WORD_SIZE'(16'hFF00)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] mem_word,
    input  logic                 mem_ready,
    input  logic [4:0]           sel_bus_1,
    input  logic [1:0]           sel_bus_2,
    input  logic                 load_reg,
    input  logic [3:0]           reg_idx,
    input  logic                 load_PC,
    input  logic                 inc_PC,
    input  logic                 load_SP,
    input  logic                 push_SP,
    input  logic                 pop_SP,
    input  logic                 load_IR,
    input  logic                 load_add_R,
    input  logic                 load_reg_Y,
    input  logic                 load_flags,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] bus_1,
    output logic [3:0]           flags,
    output logic                 stack_err,
    output logic                 stalled
);

    localparam logic [4:0] SEL_PC = 5'(NUM_REGS + SEL1_PC_OFS);
    localparam logic [4:0] SEL_SP = 5'(NUM_REGS + SEL1_SP_OFS);
    localparam logic [4:0] SEL_Y  = 5'(NUM_REGS + SEL1_Y_OFS);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic [WORD_SIZE-1:0] pc_q, pc_d, sp_q, sp_d, y_q, y_d, ir_q, ir_d, addr_q, addr_d;
    logic [3:0]           flags_q, flags_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] bus_2, alu_result;
    logic [3:0]           alu_flags;

    alu_flags_p #(.WORD_SIZE(WORD_SIZE), .OP_SIZE(OP_SIZE)) u_alu (
        .a      (y_q),
        .b      (bus_1),
        .opcode (ir_q[WORD_SIZE-1 -: OP_SIZE]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        bus_1 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_bus_1 == 5'(i)) bus_1 = regs_q[i];
        end
        if (sel_bus_1 == SEL_PC) bus_1 = pc_q;
        if (sel_bus_1 == SEL_SP) bus_1 = sp_q;
        if (sel_bus_1 == SEL_Y)  bus_1 = y_q;
    end

    always_comb begin
        case (bus2_sel_e'(sel_bus_2))
            BUS2_ALU:  bus_2 = alu_result;
            BUS2_BUS1: bus_2 = bus_1;
            BUS2_MEM:  bus_2 = mem_word;
            default:   bus_2 = '0;
        endcase
    end

    assign stalled = (bus2_sel_e'(sel_bus_2) == BUS2_MEM) && !mem_ready;

    always_comb begin
        regs_d  = regs_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        y_d     = y_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        flags_d = flags_q;
        err_d   = err_q;
        // a stall freezes every state element; control holds its inputs meanwhile
        if (!stalled) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load_reg && reg_idx == 4'(i)) regs_d[i] = bus_2;
            end
            if (load_IR)    ir_d    = bus_2;
            if (load_add_R) addr_d  = bus_2;
            if (load_reg_Y) y_d     = bus_2;
            if (load_flags) flags_d = alu_flags;

            if (load_PC)     pc_d = bus_2;
            else if (inc_PC) pc_d = pc_q + 1'b1;

            if (load_SP) begin
                sp_d = bus_2;
            end else if (push_SP && !pop_SP) begin
                if (sp_q == STACK_LIMIT) err_d = 1'b1;
                else                     sp_d  = sp_q - 1'b1;
            end else if (pop_SP && !push_SP) begin
                if (sp_q == STACK_TOP) err_d = 1'b1;
                else                   sp_d  = sp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pc_q    <= RESET_PC;
            sp_q    <= STACK_TOP;
            y_q     <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            y_q     <= y_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            flags_q <= flags_d;
            err_q   <= err_d;
        end
    end

    assign instruction = ir_q;
    assign address     = addr_q;
    assign flags       = flags_q;
    assign stack_err   = err_q;

endmodule
